// File: rtl/stepdown_gate_seq.sv
// Gate sequencer for a synchronous step-down stage: it alternates the high-side
// and low-side gate enables with fixed dead-time, on-time limits and OCP fault latching.
module stepdown_gate_seq #(
  parameter int DT_CYC  = 4,
  parameter int MIN_ON  = 8,
  parameter int MAX_ON  = 200,
  parameter int BLANK   = 6,
  parameter int OCP_MAX = 3
) (
  input  logic CELCLK,
  input  logic CELRST,
  input  logic CELV,
  input  logic CELG,
  input  logic SUB,
  input  logic en,
  input  logic pwm_req,
  input  logic ocp,
  input  logic zc,
  output logic hs_on,
  output logic ls_on,
  output logic ocp_flag,
  output logic fault
);

  // state  | meaning
  // OFF    | converter idle, both gates low
  // DT_HS  | dead-time before the high-side turns on
  // HS_ON  | high-side conducting, on-counter running
  // DT_LS  | dead-time before the low-side turns on
  // LS_ON  | low-side conducting
  // SKIP   | zero current seen, both gates low until the next request
  // FAULT  | repeated OCP, both gates low until en drops
  typedef enum logic [2:0] {
    S_OFF, S_DT_HS, S_HS_ON, S_DT_LS, S_LS_ON, S_SKIP, S_FAULT
  } state_t;

  localparam logic [7:0] DT_LOAD  = 8'(DT_CYC - 1);
  localparam logic [7:0] MIN_LAST = 8'(MIN_ON - 1);
  localparam logic [7:0] MAX_LAST = 8'(MAX_ON - 1);
  localparam logic [7:0] BLANK_C  = 8'(BLANK);
  localparam logic [7:0] OCP_LIM  = 8'(OCP_MAX);

  state_t     state_q, state_d;
  logic [7:0] dt_cnt_q, dt_cnt_d;
  logic [7:0] on_cnt_q, on_cnt_d;
  logic [7:0] ocp_cnt_q, ocp_cnt_d;
  logic       ocp_flag_d;
  logic       hs_on_q, ls_on_q, ocp_flag_q, fault_q;

  logic       ocp_exit, norm_exit;
  logic [7:0] ocp_cnt_inc;

  // Supply and substrate pins exist only for the netlist.
  logic unused_supplies;
  assign unused_supplies = CELV ^ CELG ^ SUB;

  assign ocp_exit    = ocp && (on_cnt_q >= BLANK_C);
  assign norm_exit   = (!pwm_req && (on_cnt_q >= MIN_LAST)) || (on_cnt_q == MAX_LAST);
  assign ocp_cnt_inc = ocp_cnt_q + 8'd1;

  always_comb begin
    state_d    = state_q;
    dt_cnt_d   = dt_cnt_q;
    on_cnt_d   = on_cnt_q;
    ocp_cnt_d  = ocp_cnt_q;
    ocp_flag_d = 1'b0;

    unique case (state_q)
      S_OFF: begin
        if (en && pwm_req) begin
          state_d  = S_DT_HS;
          dt_cnt_d = DT_LOAD;
        end
      end

      S_DT_HS: begin
        if (dt_cnt_q == 8'd0) begin
          state_d  = S_HS_ON;
          on_cnt_d = 8'd0;
        end else begin
          dt_cnt_d = dt_cnt_q - 8'd1;
        end
      end

      S_HS_ON: begin
        on_cnt_d = on_cnt_q + 8'd1;
        // An OCP exit outranks the on-time exits when both fire together.
        if (ocp_exit) begin
          ocp_flag_d = 1'b1;
          ocp_cnt_d  = ocp_cnt_inc;
          if (ocp_cnt_inc >= OCP_LIM) begin
            state_d = S_FAULT;
          end else begin
            state_d  = S_DT_LS;
            dt_cnt_d = DT_LOAD;
          end
        end else if (norm_exit) begin
          ocp_cnt_d = 8'd0;
          state_d   = S_DT_LS;
          dt_cnt_d  = DT_LOAD;
        end
      end

      S_DT_LS: begin
        if (dt_cnt_q == 8'd0) begin
          state_d = S_LS_ON;
        end else begin
          dt_cnt_d = dt_cnt_q - 8'd1;
        end
      end

      S_LS_ON: begin
        if (zc) begin
          state_d = S_SKIP;
        end else if (pwm_req) begin
          state_d  = S_DT_HS;
          dt_cnt_d = DT_LOAD;
        end
      end

      S_SKIP: begin
        if (pwm_req) begin
          state_d  = S_DT_HS;
          dt_cnt_d = DT_LOAD;
        end
      end

      S_FAULT: begin
        if (!en) begin
          state_d   = S_OFF;
          ocp_cnt_d = 8'd0;
        end
      end

      default: begin
        state_d = S_OFF;
      end
    endcase

    // Disable wins over everything except the fault latch, which handles en itself.
    if (!en && (state_q != S_FAULT)) begin
      state_d    = S_OFF;
      dt_cnt_d   = 8'd0;
      on_cnt_d   = 8'd0;
      ocp_cnt_d  = ocp_cnt_q;
      ocp_flag_d = 1'b0;
    end
  end

  always_ff @(posedge CELCLK) begin
    if (CELRST) begin
      state_q    <= S_OFF;
      dt_cnt_q   <= 8'd0;
      on_cnt_q   <= 8'd0;
      ocp_cnt_q  <= 8'd0;
      hs_on_q    <= 1'b0;
      ls_on_q    <= 1'b0;
      ocp_flag_q <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      dt_cnt_q   <= dt_cnt_d;
      on_cnt_q   <= on_cnt_d;
      ocp_cnt_q  <= ocp_cnt_d;
      hs_on_q    <= (state_d == S_HS_ON);
      ls_on_q    <= (state_d == S_LS_ON);
      ocp_flag_q <= ocp_flag_d;
      fault_q    <= (state_d == S_FAULT);
    end
  end

  assign hs_on    = hs_on_q;
  assign ls_on    = ls_on_q;
  assign ocp_flag = ocp_flag_q;
  assign fault    = fault_q;

endmodule

// File: tb/tb_stepdown_gate_seq.sv
// Self-checking bench for stepdown_gate_seq at default parameters: segment table
// of {inputs, cycles, expected outputs} plus hand-written reset/disable sequences.
module tb_stepdown_gate_seq;

  logic CELCLK = 1'b0;
  logic CELRST = 1'b1;
  logic CELV   = 1'b1;
  logic CELG   = 1'b0;
  logic SUB    = 1'b0;
  logic en     = 1'b0;
  logic pwm_req = 1'b0;
  logic ocp    = 1'b0;
  logic zc     = 1'b0;
  logic hs_on, ls_on, ocp_flag, fault;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected output word: {hs_on, ls_on, ocp_flag, fault}
  localparam logic [3:0] Z  = 4'b0000;
  localparam logic [3:0] H  = 4'b1000;
  localparam logic [3:0] L  = 4'b0100;
  localparam logic [3:0] F  = 4'b0010;
  localparam logic [3:0] FT = 4'b0001;

  typedef struct {
    logic       en;
    logic       pwm;
    logic       ocp;
    logic       zc;
    int         n;
    logic [3:0] exp;
  } vec_t;

  vec_t       tbl[$];
  logic [3:0] exp_q[$];

  stepdown_gate_seq dut (
    .CELCLK  (CELCLK),
    .CELRST  (CELRST),
    .CELV    (CELV),
    .CELG    (CELG),
    .SUB     (SUB),
    .en      (en),
    .pwm_req (pwm_req),
    .ocp     (ocp),
    .zc      (zc),
    .hs_on   (hs_on),
    .ls_on   (ls_on),
    .ocp_flag(ocp_flag),
    .fault   (fault)
  );

  always #5 CELCLK = ~CELCLK;

  always @(negedge CELCLK) begin
    n_checks++;
    if (hs_on && ls_on) begin
      n_fail++;
      $display("FAIL overlap t=%0t hs_on=%b ls_on=%b required not both high", $time, hs_on, ls_on);
    end
  end

  function automatic void add(input logic e, input logic p, input logic o, input logic z,
                              input int n, input logic [3:0] exp);
    vec_t v;
    v.en = e; v.pwm = p; v.ocp = o; v.zc = z; v.n = n; v.exp = exp;
    tbl.push_back(v);
  endfunction

  task automatic step(input logic rst, input logic e, input logic p, input logic o,
                      input logic z, input logic [3:0] exp, input string name);
    logic [3:0] got, want;
    CELRST = rst; en = e; pwm_req = p; ocp = o; zc = z;
    exp_q.push_back(exp);
    @(posedge CELCLK);
    #1;
    want = exp_q.pop_front();
    got  = {hs_on, ls_on, ocp_flag, fault};
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s t=%0t hs/ls/flag/fault got=%b expected=%b", name, $time, got, want);
    end
  endtask

  initial begin
    // Idle with enable but no request
    add(1,0,0,0,   3, Z);
    // Basic cycle: request held 20 cycles
    add(1,1,0,0,   4, Z);
    add(1,1,0,0,  16, H);
    add(1,0,0,0,   4, Z);
    add(1,0,0,0,   5, L);
    // Minimum on-time from a 2-cycle request
    add(1,1,0,0,   2, Z);
    add(1,0,0,0,   2, Z);
    add(1,0,0,0,   8, H);
    add(1,0,0,0,   4, Z);
    add(1,0,0,0,   3, L);
    // Maximum on-time with request held, then a min-width pulse
    add(1,1,0,0,   4, Z);
    add(1,1,0,0, 200, H);
    add(1,1,0,0,   4, Z);
    add(1,1,0,0,   1, L);
    add(1,1,0,0,   4, Z);
    add(1,0,0,0,   8, H);
    add(1,0,0,0,   4, Z);
    add(1,0,0,0,   3, L);
    // Zero-current with request pending: zc wins, SKIP then dead-time
    add(1,1,0,1,   1, Z);
    add(1,1,0,0,   4, Z);
    add(1,0,0,0,   8, H);
    add(1,0,0,0,   4, Z);
    add(1,0,0,0,   2, L);
    // Zero-current without request: SKIP holds
    add(1,0,0,1,   1, Z);
    add(1,0,0,0,   3, Z);
    add(1,1,0,0,   4, Z);
    add(1,0,0,0,   8, H);
    add(1,0,0,0,   4, Z);
    add(1,0,0,0,   2, L);
    // OCP pulse 1: ocp held, blanking hides it until count 6
    add(1,1,1,0,   4, Z);
    add(1,1,1,0,   7, H);
    add(1,1,1,0,   1, F);
    add(1,1,1,0,   3, Z);
    add(1,0,0,0,   2, L);
    // Normal pulse clears the consecutive-OCP count
    add(1,1,0,0,   1, Z);
    add(1,0,0,0,   3, Z);
    add(1,0,0,0,   8, H);
    add(1,0,0,0,   4, Z);
    add(1,0,0,0,   2, L);
    // OCP coinciding with the min-on exit is classed as OCP
    add(1,1,0,0,   1, Z);
    add(1,0,0,0,   3, Z);
    add(1,0,0,0,   8, H);
    add(1,0,1,0,   1, F);
    add(1,0,0,0,   3, Z);
    add(1,0,0,0,   2, L);
    // Second consecutive OCP
    add(1,1,1,0,   4, Z);
    add(1,1,1,0,   7, H);
    add(1,1,1,0,   1, F);
    add(1,1,1,0,   3, Z);
    add(1,0,0,0,   2, L);
    // Third consecutive OCP latches the fault
    add(1,1,1,0,   4, Z);
    add(1,1,1,0,   7, H);
    add(1,1,1,0,   1, F|FT);
    add(1,1,1,0,   5, FT);
    add(1,0,0,0,   3, FT);
    add(0,0,0,0,   1, Z);
    add(0,1,0,0,   2, Z);
    // After clearing, one OCP pulse only flags
    add(1,1,1,0,   4, Z);
    add(1,1,1,0,   7, H);
    add(1,1,1,0,   1, F);
    add(1,1,1,0,   3, Z);
    add(1,0,0,0,   2, L);
    // Disable mid high-side pulse
    add(1,1,0,0,   4, Z);
    add(1,1,0,0,   3, H);
    add(0,1,0,0,   2, Z);
    add(1,0,0,0,   2, Z);

    // Reset state, and reset priority over en
    step(1, 0,0,0,0, Z, "reset_idle");
    step(1, 0,0,0,0, Z, "reset_idle");
    step(1, 1,1,0,0, Z, "reset_over_en");
    step(1, 1,1,0,0, Z, "reset_over_en");

    foreach (tbl[i]) begin
      for (int k = 0; k < tbl[i].n; k++) begin
        step(0, tbl[i].en, tbl[i].pwm, tbl[i].ocp, tbl[i].zc, tbl[i].exp,
             $sformatf("vec%0d_cyc%0d", i, k));
      end
    end

    // Reset mid high-side pulse
    begin
      bit seen;
      seen = 0;
      CELRST = 0; en = 1; pwm_req = 1; ocp = 0; zc = 0;
      for (int k = 0; k < 20 && !seen; k++) begin
        @(posedge CELCLK);
        #1;
        if (hs_on) seen = 1;
      end
      n_checks++;
      if (!seen) begin
        n_fail++;
        $display("FAIL hs_wait_timeout hs_on got=0 expected=1 within 20 cycles");
      end
      step(0, 1,1,0,0, H, "hs_before_reset");
      step(1, 1,1,0,0, Z, "reset_mid_pulse");
      step(0, 1,0,0,0, Z, "off_after_reset");
      step(0, 1,1,0,0, Z, "restart_dt0");
      step(0, 1,1,0,0, Z, "restart_dt1");
      step(0, 1,1,0,0, Z, "restart_dt2");
      step(0, 1,1,0,0, Z, "restart_dt3");
      step(0, 1,1,0,0, H, "restart_hs");
      step(0, 0,1,0,0, Z, "disable_drop");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/stepdown_gate_seq.md
STEPDOWN_GATE_SEQ -- requirements
Module: stepdown_gate_seq

Interface
REQ-001 Parameter DT_CYC, default 4: dead-time in clock cycles during which both gate outputs are low (valid range 1-255).
REQ-002 Parameter MIN_ON, default 8: minimum high-side on-time in cycles.
REQ-003 Parameter MAX_ON, default 200: maximum high-side on-time in cycles (MIN_ON <= MAX_ON <= 255).
REQ-004 Parameter BLANK, default 6: leading-edge blanking in cycles; ocp is ignored while HS has been on for fewer than BLANK cycles.
REQ-005 Parameter OCP_MAX, default 3: consecutive OCP-terminated pulses that cause a fault latch.
REQ-006 CELCLK  input  1  the block's single clock; all state changes on its rising edge.
REQ-007 CELRST  input  1  synchronous, active-high reset, sampled on CELCLK.
REQ-008 CELV, CELG, SUB  input  1 each  supply, ground and substrate pins; no functional effect.
REQ-009 en  input  1  converter enable.
REQ-010 pwm_req  input  1  loop comparator request for high-side conduction.
REQ-011 ocp  input  1  over-current comparator output.
REQ-012 zc  input  1  low-side zero-current detect.
REQ-013 hs_on  output  1  high-side gate enable; feeds the control nand3 stage.
REQ-014 ls_on  output  1  low-side gate enable.
REQ-015 ocp_flag  output  1  high for one cycle when a pulse is terminated by ocp.
REQ-016 fault  output  1  latched OCP fault.

Function
REQ-017 States: OFF, DT_HS, HS_ON, DT_LS, LS_ON, SKIP, FAULT; all outputs are registered.
REQ-018 hs_on=1 only in HS_ON, and ls_on=1 only in LS_ON; hs_on and ls_on are never high in the same cycle.
REQ-019 OFF: if en && pwm_req, go to DT_HS.
REQ-020 DT_HS and DT_LS: stay exactly DT_CYC cycles, then go to HS_ON and LS_ON respectively.
REQ-021 HS_ON: an 8-bit on-counter starts at 0 on entry and increments each cycle.
REQ-022 HS_ON exit to DT_LS on the first of:
- ocp && count >= BLANK (an OCP exit);
- !pwm_req && count >= MIN_ON-1;
- count == MAX_ON-1.
REQ-023 If the OCP exit and the other exit conditions occur in the same cycle, the exit is classed as an OCP exit.
REQ-024 On an OCP exit: ocp_flag pulses for 1 cycle and the consecutive-OCP counter increments.
REQ-025 On any other HS_ON exit, the consecutive-OCP counter clears to 0.
REQ-026 When the consecutive-OCP counter reaches OCP_MAX, go to FAULT instead of DT_LS.
REQ-027 LS_ON: if zc, go to SKIP (ls_on low the next cycle). Otherwise, if pwm_req, go to DT_HS.
REQ-028 If zc and pwm_req are both set in LS_ON, zc wins.
REQ-029 SKIP: both outputs low; go to DT_HS when pwm_req.
REQ-030 FAULT: both outputs low and fault=1; leave only when en=0, then go to OFF and clear fault and the consecutive-OCP counter.
REQ-031 en=0 in any state other than FAULT: go to OFF on the next edge, and hs_on and ls_on drop in that same cycle.
REQ-032 en=0 has priority over all other transitions.
REQ-033 en=1 with pwm_req=0 leaves the block in OFF indefinitely.
REQ-034 Resulting pulse widths: HS pulse width is in [MIN_ON, MAX_ON] cycles unless the pulse ends by OCP or en=0; dead-time is exactly DT_CYC cycles at each HS-to-LS and LS-to-HS edge.

Reset
REQ-035 While CELRST=1 on an edge: state=OFF, all counters=0, and hs_on=ls_on=ocp_flag=fault=0.
REQ-036 Reset asserted mid-pulse forces both gates low on the next edge, whatever the state; CELRST has priority over en.

Verification
REQ-037 Basic PWM cycle:
- Stimulus: after reset, en=1, pwm_req=1 held 20 cycles, then 0.
- Response: hs_on rises 4 cycles after entering DT_HS and stays high until pwm_req falls (at least 8 cycles); ls_on rises exactly 4 cycles after hs_on falls.
REQ-038 Minimum on-time:
- Stimulus: pwm_req pulsed for 2 cycles.
- Response: hs_on high for exactly 8 cycles.
REQ-039 Maximum on-time:
- Stimulus: pwm_req held high.
- Response: hs_on high for exactly 200 cycles, then 4 dead cycles, then ls_on.
REQ-040 Blanking and OCP termination:
- Stimulus: ocp=1 from cycle 2 of HS_ON.
- Response: termination at count 6; ocp_flag pulses once.
- Then: three consecutive OCP-terminated pulses give fault=1 with both gates low; fault clears only after en=0 for one edge.
REQ-041 Zero-current skip:
- Stimulus: zc=1 during LS_ON while pwm_req=1.
- Response: ls_on falls next cycle, SKIP is entered, and the next HS pulse begins after 4 dead cycles.
REQ-042 Disable and reset mid-pulse:
- Stimulus: en=0 or CELRST=1 mid HS_ON.
- Response: hs_on=ls_on=0 on the next edge; no overlap is ever observed.
- Continuous assertion throughout the bench: !(hs_on && ls_on).
